// File: rtl/id_stage_pipelined.sv
// rtl/id_stage_pipelined.sv - ARM decode stage: control decode, condition check, register file, hazard detect, ID/EX register
module id_stage_pipelined #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int FWD_EN     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic [31:0]           instr_in,
    input  logic                  instr_valid,
    input  logic [3:0]            status,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  wb_en_in,
    input  logic [3:0]            wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_value,
    input  logic                  ex_wb_en,
    input  logic                  ex_mem_r_en,
    input  logic [3:0]            ex_dest,
    input  logic                  mem_wb_en,
    input  logic [3:0]            mem_dest,
    output logic                  hazard,
    output logic [PC_WIDTH-1:0]   pc_out,
    output logic                  valid_out,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic                  wb_en,
    output logic                  status_w_en,
    output logic                  branch_taken,
    output logic                  imm,
    output logic [3:0]            exec_cmd,
    output logic [DATA_WIDTH-1:0] val_rn,
    output logic [DATA_WIDTH-1:0] val_rm,
    output logic [3:0]            src1,
    output logic [3:0]            src2,
    output logic [3:0]            dest,
    output logic [23:0]           signed_imm24,
    output logic [11:0]           shift_operand
);

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic                  valid;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  wb_en;
        logic                  status_w_en;
        logic                  branch_taken;
        logic                  imm;
        logic [3:0]            exec_cmd;
        logic [DATA_WIDTH-1:0] val_rn;
        logic [DATA_WIDTH-1:0] val_rm;
        logic [3:0]            src1;
        logic [3:0]            src2;
        logic [3:0]            dest;
        logic [23:0]           signed_imm24;
        logic [11:0]           shift_operand;
    } idex_t;

    logic [3:0] cond;
    logic [1:0] mode;
    logic       i_bit;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;

    assign cond   = instr_in[31:28];
    assign mode   = instr_in[27:26];
    assign i_bit  = instr_in[25];
    assign opcode = instr_in[24:21];
    assign s_bit  = instr_in[20];
    assign rn     = instr_in[19:16];
    assign rd     = instr_in[15:12];
    assign rm     = instr_in[3:0];

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = status;

    logic cond_pass;
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    logic [3:0] d_cmd;
    logic       d_wb, d_mr, d_mw, d_br, d_sw;
    always_comb begin
        d_cmd = 4'b0000;
        d_wb  = 1'b0;
        d_mr  = 1'b0;
        d_mw  = 1'b0;
        d_br  = 1'b0;
        case (mode)
            2'b00: begin
                case (opcode)
                    4'b1101: begin d_cmd = 4'b0001; d_wb = 1'b1; end
                    4'b1111: begin d_cmd = 4'b1001; d_wb = 1'b1; end
                    4'b0100: begin d_cmd = 4'b0010; d_wb = 1'b1; end
                    4'b0101: begin d_cmd = 4'b0011; d_wb = 1'b1; end
                    4'b0010: begin d_cmd = 4'b0100; d_wb = 1'b1; end
                    4'b0110: begin d_cmd = 4'b0101; d_wb = 1'b1; end
                    4'b0000: begin d_cmd = 4'b0110; d_wb = 1'b1; end
                    4'b1100: begin d_cmd = 4'b0111; d_wb = 1'b1; end
                    4'b0001: begin d_cmd = 4'b1000; d_wb = 1'b1; end
                    4'b1010: d_cmd = 4'b0100;
                    4'b1000: d_cmd = 4'b0110;
                    default: ;
                endcase
            end
            2'b01: begin
                d_cmd = 4'b0010;
                d_mr  = s_bit;
                d_wb  = s_bit;
                d_mw  = ~s_bit;
            end
            2'b10: d_br = 1'b1;
            default: ;
        endcase
    end

    // every recognised data-processing opcode has a nonzero ALU command
    assign d_sw = (mode == 2'b00) && (d_cmd != 4'b0000) && s_bit;

    logic       is_str;
    logic [3:0] src2_idx;
    logic       rn_used;
    logic       src2_used;

    assign is_str    = (mode == 2'b01) && !s_bit;
    assign src2_idx  = is_str ? rd : rm;
    assign rn_used   = !((mode == 2'b10) ||
                         ((mode == 2'b00) && ((opcode == 4'b1101) || (opcode == 4'b1111))));
    assign src2_used = ((mode == 2'b00) && !i_bit) || is_str;

    generate
        if (FWD_EN != 0) begin : g_fwd_hazard
            // forwarding covers everything except a load still in EX
            assign hazard = instr_valid && ex_wb_en && ex_mem_r_en &&
                            ((rn_used && (ex_dest == rn)) || (src2_used && (ex_dest == src2_idx)));
        end else begin : g_stall_hazard
            assign hazard = instr_valid &&
                ((rn_used && ((ex_wb_en && (ex_dest == rn)) || (mem_wb_en && (mem_dest == rn)))) ||
                 (src2_used && ((ex_wb_en && (ex_dest == src2_idx)) ||
                                (mem_wb_en && (mem_dest == src2_idx)))));
        end
    endgenerate

    logic [DATA_WIDTH-1:0] regs [16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en_in) begin
            regs[wb_dest] <= wb_value;
        end
    end

    logic [DATA_WIDTH-1:0] rn_data;
    logic [DATA_WIDTH-1:0] rm_data;
    assign rn_data = (wb_en_in && (wb_dest == rn))       ? wb_value : regs[rn];
    assign rm_data = (wb_en_in && (wb_dest == src2_idx)) ? wb_value : regs[src2_idx];

    idex_t idex_d;
    idex_t idex_q;

    always_comb begin
        idex_d               = '0;
        idex_d.pc            = pc_in;
        idex_d.valid         = 1'b1;
        idex_d.mem_r_en      = d_mr & cond_pass;
        idex_d.mem_w_en      = d_mw & cond_pass;
        idex_d.wb_en         = d_wb & cond_pass;
        idex_d.status_w_en   = d_sw & cond_pass;
        idex_d.branch_taken  = d_br & cond_pass;
        idex_d.imm           = i_bit;
        idex_d.exec_cmd      = cond_pass ? d_cmd : 4'b0000;
        idex_d.val_rn        = rn_data;
        idex_d.val_rm        = rm_data;
        idex_d.src1          = rn;
        idex_d.src2          = src2_idx;
        idex_d.dest          = rd;
        idex_d.signed_imm24  = instr_in[23:0];
        idex_d.shift_operand = instr_in[11:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else if (flush) begin
            idex_q <= '0;
        end else if (!freeze) begin
            if (hazard || !instr_valid) begin
                idex_q <= '0;
            end else begin
                idex_q <= idex_d;
            end
        end
    end

    assign pc_out        = idex_q.pc;
    assign valid_out     = idex_q.valid;
    assign mem_r_en      = idex_q.mem_r_en;
    assign mem_w_en      = idex_q.mem_w_en;
    assign wb_en         = idex_q.wb_en;
    assign status_w_en   = idex_q.status_w_en;
    assign branch_taken  = idex_q.branch_taken;
    assign imm           = idex_q.imm;
    assign exec_cmd      = idex_q.exec_cmd;
    assign val_rn        = idex_q.val_rn;
    assign val_rm        = idex_q.val_rm;
    assign src1          = idex_q.src1;
    assign src2          = idex_q.src2;
    assign dest          = idex_q.dest;
    assign signed_imm24  = idex_q.signed_imm24;
    assign shift_operand = idex_q.shift_operand;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb/tb_id_stage_pipelined.sv - self-checking bench for id_stage_pipelined (stall and forwarding variants)
module tb_id_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic [3:0]  status;
    logic        freeze, flush;
    logic        wb_en_in;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        ex_wb_en, ex_mem_r_en;
    logic [3:0]  ex_dest;
    logic        mem_wb_en;
    logic [3:0]  mem_dest;

    logic        hazard0, valid_out0, mem_r_en0, mem_w_en0, wb_en0, status_w_en0, branch_taken0, imm0;
    logic [31:0] pc_out0, val_rn0, val_rm0;
    logic [3:0]  exec_cmd0, src1_0, src2_0, dest0;
    logic [23:0] signed_imm24_0;
    logic [11:0] shift_operand0;

    logic        hazard1, valid_out1, mem_r_en1, mem_w_en1, wb_en1, status_w_en1, branch_taken1, imm1;
    logic [31:0] pc_out1, val_rn1, val_rm1;
    logic [3:0]  exec_cmd1, src1_1, src2_1, dest1;
    logic [23:0] signed_imm24_1;
    logic [11:0] shift_operand1;

    always #5 clk = ~clk;

    id_stage_pipelined #(.DATA_WIDTH(32), .PC_WIDTH(32), .FWD_EN(0)) dut0 (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .instr_valid(instr_valid),
        .status(status), .freeze(freeze), .flush(flush), .wb_en_in(wb_en_in), .wb_dest(wb_dest),
        .wb_value(wb_value), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_dest(ex_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard(hazard0), .pc_out(pc_out0),
        .valid_out(valid_out0), .mem_r_en(mem_r_en0), .mem_w_en(mem_w_en0), .wb_en(wb_en0),
        .status_w_en(status_w_en0), .branch_taken(branch_taken0), .imm(imm0), .exec_cmd(exec_cmd0),
        .val_rn(val_rn0), .val_rm(val_rm0), .src1(src1_0), .src2(src2_0), .dest(dest0),
        .signed_imm24(signed_imm24_0), .shift_operand(shift_operand0)
    );

    id_stage_pipelined #(.DATA_WIDTH(32), .PC_WIDTH(32), .FWD_EN(1)) dut1 (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .instr_valid(instr_valid),
        .status(status), .freeze(freeze), .flush(flush), .wb_en_in(wb_en_in), .wb_dest(wb_dest),
        .wb_value(wb_value), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_dest(ex_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard(hazard1), .pc_out(pc_out1),
        .valid_out(valid_out1), .mem_r_en(mem_r_en1), .mem_w_en(mem_w_en1), .wb_en(wb_en1),
        .status_w_en(status_w_en1), .branch_taken(branch_taken1), .imm(imm1), .exec_cmd(exec_cmd1),
        .val_rn(val_rn1), .val_rm(val_rm1), .src1(src1_1), .src2(src2_1), .dest(dest1),
        .signed_imm24(signed_imm24_1), .shift_operand(shift_operand1)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        valid, mr, mw, wb, sw, br, imm;
        logic [3:0]  cmd;
        logic [31:0] rn, rm;
        logic [3:0]  s1, s2, dest;
        logic [23:0] simm;
        logic [11:0] shop;
    } out_t;

    out_t act0, act1;
    assign act0 = {pc_out0, valid_out0, mem_r_en0, mem_w_en0, wb_en0, status_w_en0, branch_taken0, imm0,
                   exec_cmd0, val_rn0, val_rm0, src1_0, src2_0, dest0, signed_imm24_0, shift_operand0};
    assign act1 = {pc_out1, valid_out1, mem_r_en1, mem_w_en1, wb_en1, status_w_en1, branch_taken1, imm1,
                   exec_cmd1, val_rn1, val_rm1, src1_1, src2_1, dest1, signed_imm24_1, shift_operand1};

    int nchecks = 0;
    int nerrs   = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference architectural state and decode tables
    logic [31:0] ref_regs [16];
    logic [3:0]  cmd_of [16];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ref_regs[i] <= '0;
        end else if (wb_en_in) begin
            ref_regs[wb_dest] <= wb_value;
        end
    end

    function automatic logic [31:0] rd_ref(input logic [3:0] idx);
        return (wb_en_in && wb_dest == idx) ? wb_value : ref_regs[idx];
    endfunction

    // ARM pairs conditions: odd codes are the negation of the even code below them
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0]) r = !r;
        if (c == 4'hF) r = 1'b0;
        return r;
    endfunction

    function automatic out_t ref_decode();
        out_t o;
        logic [1:0] md;
        logic [3:0] op;
        logic       s, st;
        o  = '0;
        md = instr_in[27:26];
        op = instr_in[24:21];
        s  = instr_in[20];
        st = (md == 2'd1) && !s;
        o.pc    = pc_in;
        o.valid = 1'b1;
        o.imm   = instr_in[25];
        o.s1    = instr_in[19:16];
        o.s2    = st ? instr_in[15:12] : instr_in[3:0];
        o.dest  = instr_in[15:12];
        o.simm  = instr_in[23:0];
        o.shop  = instr_in[11:0];
        o.rn    = rd_ref(o.s1);
        o.rm    = rd_ref(o.s2);
        if (cond_ok(instr_in[31:28], status)) begin
            if (md == 2'd0 && cmd_of[op] != 4'd0) begin
                o.cmd = cmd_of[op];
                o.wb  = !(op == 4'd8 || op == 4'd10);
                o.sw  = s;
            end else if (md == 2'd1) begin
                o.cmd = 4'd2;
                o.mr  = s;
                o.wb  = s;
                o.mw  = !s;
            end else if (md == 2'd2) begin
                o.br = 1'b1;
            end
        end
        return o;
    endfunction

    function automatic logic ref_hazard(input bit fwd);
        logic [3:0] srcs[$];
        logic [1:0] md;
        logic [3:0] op;
        logic       st;
        md = instr_in[27:26];
        op = instr_in[24:21];
        st = (md == 2'd1) && !instr_in[20];
        if (!instr_valid) return 1'b0;
        if (!(md == 2'd2 || (md == 2'd0 && (op == 4'd13 || op == 4'd15))))
            srcs.push_back(instr_in[19:16]);
        if ((md == 2'd0 && !instr_in[25]) || st)
            srcs.push_back(st ? instr_in[15:12] : instr_in[3:0]);
        foreach (srcs[k]) begin
            if (fwd) begin
                if (ex_wb_en && ex_mem_r_en && srcs[k] == ex_dest) return 1'b1;
            end else begin
                if ((ex_wb_en && srcs[k] == ex_dest) || (mem_wb_en && srcs[k] == mem_dest)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic out_t ref_next(input out_t cur, input logic haz);
        if (flush) return '0;
        if (freeze) return cur;
        if (haz || !instr_valid) return '0;
        return ref_decode();
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  st;
        logic        ex_wb, ex_mr;
        logic [3:0]  ex_d;
        logic        mem_wb;
        logic [3:0]  mem_d;
        logic        haz0, haz1, v0, v1;
        logic [3:0]  cmd;
        logic        wb, mr, mw, sw, br;
        logic [31:0] rn, rm;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] ADD = 32'hE0821003;

    task automatic clear_inputs();
        pc_in = '0; instr_in = '0; instr_valid = 1'b0; status = '0; freeze = 1'b0; flush = 1'b0;
        wb_en_in = 1'b0; wb_dest = '0; wb_value = '0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0;
        ex_dest = '0; mem_wb_en = 1'b0; mem_dest = '0;
    endtask

    task automatic reg_write(input logic [3:0] idx, input logic [31:0] val);
        instr_valid = 1'b0; wb_en_in = 1'b1; wb_dest = idx; wb_value = val;
        @(posedge clk); #1;
        wb_en_in = 1'b0;
    endtask

    out_t exp0, exp1, n0, n1;
    logic h0, h1;

    initial begin
        cmd_of = '{4'h6, 4'h8, 4'h4, 4'h0, 4'h2, 4'h3, 4'h5, 4'h0,
                   4'h6, 4'h0, 4'h4, 4'h0, 4'h7, 4'h1, 4'h0, 4'h9};
        //               instr         st    exwb mr exd memwb memd h0 h1 v0 v1 cmd wb mr mw sw br  rn rm
        vecs.push_back('{ADD,          4'h0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, 4'h2, 1, 0, 0, 0, 0, 7, 9});
        vecs.push_back('{32'hE3A00005, 4'h0, 1, 1, 4'd0, 1, 4'd0, 0, 0, 1, 1, 4'h1, 1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{32'hE5914008, 4'h0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, 4'h2, 1, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{32'h00821003, 4'h0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, 0, 7, 9});
        vecs.push_back('{32'h00821003, 4'h4, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, 4'h2, 1, 0, 0, 0, 0, 7, 9});
        vecs.push_back('{ADD,          4'h0, 1, 0, 4'd3, 0, 4'd0, 1, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{ADD,          4'h0, 1, 1, 4'd3, 0, 4'd0, 1, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{ADD,          4'h0, 1, 1, 4'd1, 1, 4'd1, 0, 0, 1, 1, 4'h2, 1, 0, 0, 0, 0, 7, 9});
        vecs.push_back('{32'hE5812000, 4'h0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, 4'h2, 0, 0, 1, 0, 0, 0, 7});
        vecs.push_back('{32'hE5812000, 4'h0, 0, 0, 4'd0, 1, 4'd2, 1, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{32'hEA000010, 4'h0, 1, 1, 4'd0, 1, 4'd0, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{32'hF0821003, 4'hF, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, 0, 7, 9});
        vecs.push_back('{32'hE1520003, 4'h0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, 4'h4, 0, 0, 0, 1, 0, 7, 9});
        vecs.push_back('{32'hE0621003, 4'h0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, 0, 7, 9});

        clear_inputs();
        rst = 1'b1;
        #3;
        chk("reset_out0", act0, '0);
        chk("reset_out1", act1, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        reg_write(4'd2, 32'd7);
        reg_write(4'd3, 32'd9);

        for (int i = 0; i < vecs.size(); i++) begin
            instr_in = vecs[i].instr; status = vecs[i].st; pc_in = 32'h10 + 32'(4 * i);
            instr_valid = 1'b1; ex_wb_en = vecs[i].ex_wb; ex_mem_r_en = vecs[i].ex_mr;
            ex_dest = vecs[i].ex_d; mem_wb_en = vecs[i].mem_wb; mem_dest = vecs[i].mem_d;
            #2;
            chk($sformatf("vec%0d_hazard0", i), hazard0, vecs[i].haz0);
            chk($sformatf("vec%0d_hazard1", i), hazard1, vecs[i].haz1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid0", i), valid_out0, vecs[i].v0);
            chk($sformatf("vec%0d_valid1", i), valid_out1, vecs[i].v1);
            chk($sformatf("vec%0d_ctl", i),
                {exec_cmd0, wb_en0, mem_r_en0, mem_w_en0, status_w_en0, branch_taken0},
                {vecs[i].cmd, vecs[i].wb, vecs[i].mr, vecs[i].mw, vecs[i].sw, vecs[i].br});
            if (vecs[i].v0) begin
                chk($sformatf("vec%0d_pc", i), pc_out0, 32'h10 + 32'(4 * i));
                chk($sformatf("vec%0d_operands", i), {val_rn0, val_rm0}, {vecs[i].rn, vecs[i].rm});
            end
        end

        // write-through bypass, then the stored value
        instr_in = ADD; pc_in = 32'h100; status = '0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0;
        mem_wb_en = 1'b0; wb_en_in = 1'b1; wb_dest = 4'd2; wb_value = 32'h1234;
        @(posedge clk); #1;
        wb_en_in = 1'b0;
        chk("wt_val_rn", val_rn0, 32'h1234);
        chk("wt_val_rm", val_rm0, 32'd9);
        @(posedge clk); #1;
        chk("wt_stored", val_rn0, 32'h1234);

        freeze = 1'b1; instr_in = 32'hE3A00005; pc_in = 32'h200;
        @(posedge clk); #1;
        chk("freeze_hold", {valid_out0, exec_cmd0, dest0, imm0, val_rn0, pc_out0},
            {1'b1, 4'h2, 4'h1, 1'b0, 32'h1234, 32'h100});

        flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_over_freeze", {valid_out0, wb_en0, exec_cmd0, valid_out1}, '0);

        freeze = 1'b0; instr_in = ADD; ex_wb_en = 1'b1; ex_dest = 4'd3;
        #2;
        chk("flush_hazard_comb", hazard0, 1'b1);
        @(posedge clk); #1;
        chk("flush_hazard_valid", valid_out0, 1'b0);
        flush = 1'b0; ex_wb_en = 1'b0;

        instr_in = 32'hE3A00005;
        @(posedge clk); #1;
        chk("mov_fields", {valid_out0, shift_operand0, imm0, exec_cmd0, wb_en0},
            {1'b1, 12'h005, 1'b1, 4'h1, 1'b1});

        instr_in = ADD;
        @(posedge clk); #1;
        chk("pre_reset_valid", valid_out0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out0", act0, '0);
        chk("async_rst_out1", act1, '0);
        #1;
        rst = 1'b0;

        exp0 = '0;
        exp1 = '0;
        for (int c = 0; c < 400; c++) begin
            instr_in = $urandom;
            if ($urandom_range(0, 1) == 0) instr_in[31:28] = 4'hE;
            pc_in       = $urandom;
            status      = 4'($urandom_range(0, 15));
            instr_valid = ($urandom_range(0, 9) != 0);
            freeze      = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 11) == 0);
            wb_en_in    = ($urandom_range(0, 2) == 0);
            wb_dest     = 4'($urandom_range(0, 15));
            wb_value    = $urandom;
            ex_wb_en    = 1'($urandom_range(0, 1));
            ex_mem_r_en = 1'($urandom_range(0, 1));
            ex_dest     = 4'($urandom_range(0, 15));
            mem_wb_en   = 1'($urandom_range(0, 1));
            mem_dest    = 4'($urandom_range(0, 15));
            #2;
            h0 = ref_hazard(1'b0);
            h1 = ref_hazard(1'b1);
            chk($sformatf("rnd%0d_hazard0", c), hazard0, h0);
            chk($sformatf("rnd%0d_hazard1", c), hazard1, h1);
            n0 = ref_next(exp0, h0);
            n1 = ref_next(exp1, h1);
            @(posedge clk); #1;
            exp0 = n0;
            exp1 = n1;
            chk($sformatf("rnd%0d_out0", c), act0, exp0);
            chk($sformatf("rnd%0d_out1", c), act1, exp1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
